// File: rtl/rally_controller.sv
// rally_controller: match sequencer that freezes play after points, serves the ball after a pause and handles start/game over.
module rally_controller #(
  parameter int TICK_DIV    = 650_000,
  parameter int HOLD_TICKS  = 150,
  parameter int SERVE_TICKS = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn,
  input  logic [3:0] score_player1,
  input  logic [3:0] score_player2,
  input  logic       endgame,
  output logic       freeze,
  output logic       ball_reset,
  output logic       serve_side,
  output logic       game_reset,
  output logic       game_over
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  typedef enum logic [2:0] {IDLE, SERVE, PLAY, POINT_HOLD, GAMEOVER} state_t;
  state_t state, nxt;
  logic [PW-1:0] pcnt;
  logic [7:0] tcnt;
  logic [1:0] sync;
  logic sync_d, start_rise;
  logic [3:0] prev_s1, prev_s2;
  logic tick, p1_pt, p2_pt, start_ok;
  assign tick = pcnt == PW'(TICK_DIV - 1);
  assign p1_pt = score_player1 != prev_s1;
  assign p2_pt = score_player2 != prev_s2;
  assign start_ok = start_rise && (state == IDLE || state == GAMEOVER);
  always_comb begin
    nxt = state;
    case (state)
      IDLE, GAMEOVER: nxt = start_rise ? SERVE : state;
      SERVE:          nxt = tick && tcnt == 8'(SERVE_TICKS - 1) ? PLAY : SERVE;
      PLAY:           nxt = endgame ? GAMEOVER : (p1_pt || p2_pt) ? POINT_HOLD : PLAY;
      POINT_HOLD:     nxt = tick && tcnt == 8'(HOLD_TICKS - 1) ? (endgame ? GAMEOVER : SERVE) : POINT_HOLD;
      default:        nxt = IDLE;
    endcase
  end
  // outputs are decoded from the next state so they are registered with it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt       <= '0;
      sync       <= '0;
      sync_d     <= 1'b0;
      start_rise <= 1'b0;
      prev_s1    <= '0;
      prev_s2    <= '0;
      state      <= IDLE;
      tcnt       <= '0;
      freeze     <= 1'b1;
      ball_reset <= 1'b0;
      serve_side <= 1'b0;
      game_reset <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      pcnt       <= tick ? '0 : pcnt + 1'b1;
      sync       <= {sync[0], start_btn};
      sync_d     <= sync[1];
      start_rise <= sync[1] & ~sync_d;
      prev_s1    <= score_player1;
      prev_s2    <= score_player2;
      state      <= nxt;
      tcnt       <= nxt != state ? '0 : tcnt + 8'(tick);
      freeze     <= nxt != PLAY;
      ball_reset <= nxt == SERVE;
      game_over  <= nxt == GAMEOVER;
      game_reset <= start_ok;
      serve_side <= start_ok ? 1'b0 : (state == PLAY && !endgame && (p1_pt || p2_pt)) ? !p1_pt : serve_side;
    end
  end
endmodule

// File: tb/tb_rally_controller.sv
// tb_rally_controller: directed vector table, async reset sequence and randomized run against a reference model.
module tb_rally_controller;
  localparam int TD = 4, HT = 3, ST = 2;
  localparam int M_IDLE = 0, M_SERVE = 1, M_PLAY = 2, M_HOLD = 3, M_OVER = 4;
  logic clk = 0, rst = 0, start_btn = 0, endgame = 0;
  logic [3:0] s1 = 0, s2 = 0;
  logic freeze, ball_reset, serve_side, game_reset, game_over;
  logic [4:0] o;
  int checks = 0, errors = 0;
  typedef struct {
    logic       btn;
    logic [3:0] a;
    logic [3:0] b;
    logic       eg;
    int         n;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[20];
  int k, mode, mt;
  logic [3:0] bh, p1, p2;
  logic m_ss, m_gr;

  always #5 clk = ~clk;
  assign o = {freeze, ball_reset, serve_side, game_reset, game_over};

  rally_controller #(.TICK_DIV(TD), .HOLD_TICKS(HT), .SERVE_TICKS(ST)) dut (
    .clk(clk), .rst(rst), .start_btn(start_btn),
    .score_player1(s1), .score_player2(s2), .endgame(endgame),
    .freeze(freeze), .ball_reset(ball_reset), .serve_side(serve_side),
    .game_reset(game_reset), .game_over(game_over)
  );

  task automatic check(input string name, input logic [4:0] exp);
    checks++;
    if (o !== exp) begin
      errors++;
      $display("FAIL %s got {frz,br,ss,gr,go}=%b expected %b at %0t", name, o, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic void model_reset();
    k = 0; bh = '0; mode = M_IDLE; mt = 0; m_ss = 0; m_gr = 0; p1 = 0; p2 = 0;
  endfunction

  // bh[i] holds the button value sampled i+1 edges ago
  function automatic void model_edge(input logic btn, input logic [3:0] a, input logic [3:0] b, input logic eg);
    logic tk, start;
    int nm;
    tk = (k % TD) == TD - 1;
    start = bh[2] && !bh[3];
    nm = mode;
    m_gr = 0;
    if ((mode == M_IDLE || mode == M_OVER) && start) begin
      nm = M_SERVE; m_gr = 1; m_ss = 0;
    end else if (mode == M_SERVE && tk && mt + 1 == ST) nm = M_PLAY;
    else if (mode == M_PLAY) begin
      if (eg) nm = M_OVER;
      else if (a != p1) begin nm = M_HOLD; m_ss = 0; end
      else if (b != p2) begin nm = M_HOLD; m_ss = 1; end
    end else if (mode == M_HOLD && tk && mt + 1 == HT) nm = eg ? M_OVER : M_SERVE;
    mt = nm != mode ? 0 : mt + (tk ? 1 : 0);
    mode = nm;
    p1 = a;
    p2 = b;
    bh = {bh[2:0], btn};
    k++;
  endfunction

  function automatic logic [4:0] model_out();
    return {mode != M_PLAY, mode == M_SERVE, m_ss, m_gr, mode == M_OVER};
  endfunction

  initial begin
    tbl[0]  = '{1, 0, 0, 0, 3,  5'b10000};
    tbl[1]  = '{1, 0, 0, 0, 1,  5'b11010};
    tbl[2]  = '{0, 0, 0, 0, 1,  5'b11000};
    tbl[3]  = '{0, 0, 0, 0, 6,  5'b11000};
    tbl[4]  = '{0, 0, 0, 0, 1,  5'b00000};
    tbl[5]  = '{0, 0, 1, 0, 1,  5'b10100};
    tbl[6]  = '{0, 0, 1, 0, 10, 5'b10100};
    tbl[7]  = '{0, 0, 1, 0, 1,  5'b11100};
    tbl[8]  = '{0, 1, 1, 0, 7,  5'b11100};
    tbl[9]  = '{0, 1, 1, 0, 1,  5'b00100};
    tbl[10] = '{1, 1, 1, 0, 6,  5'b00100};
    tbl[11] = '{0, 2, 2, 0, 1,  5'b10000};
    tbl[12] = '{0, 3, 2, 0, 8,  5'b10000};
    tbl[13] = '{0, 3, 2, 0, 1,  5'b11000};
    tbl[14] = '{0, 3, 2, 0, 8,  5'b00000};
    tbl[15] = '{0, 3, 3, 1, 1,  5'b10001};
    tbl[16] = '{0, 3, 3, 1, 3,  5'b10001};
    tbl[17] = '{1, 0, 0, 0, 3,  5'b10001};
    tbl[18] = '{1, 0, 0, 0, 1,  5'b11010};
    tbl[19] = '{1, 0, 0, 0, 1,  5'b11000};
    #12;
    check("reset_values", 5'b10000);
    @(negedge clk);
    rst = 1;
    for (int i = 0; i < 20; i++) begin
      start_btn = tbl[i].btn;
      s1 = tbl[i].a;
      s2 = tbl[i].b;
      endgame = tbl[i].eg;
      step(tbl[i].n);
      check($sformatf("vec%0d", i), tbl[i].exp);
    end
    start_btn = 0;
    begin
      int w = 0;
      while (freeze !== 1'b0 && w < 50) begin
        step(1);
        w++;
      end
    end
    check("reach_play", 5'b00000);
    s2 = 1;
    step(1);
    check("hold_p2", 5'b10100);
    step(1);
    #2 rst = 0;
    #1 check("async_reset", 5'b10000);
    @(posedge clk);
    #1 rst = 1;
    repeat (30) begin
      step(1);
      check("idle_after_reset", 5'b10000);
    end
    start_btn = 1;
    step(3);
    check("restart_wait", 5'b10000);
    step(1);
    check("restart_pulse", 5'b11010);
    start_btn = 0;
    step(1);
    rst = 0;
    s1 = 0; s2 = 0; endgame = 0;
    step(1);
    rst = 1;
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(9) == 0) start_btn = ~start_btn;
      if ($urandom_range(24) == 0) s1 = 4'($urandom_range(15));
      if ($urandom_range(24) == 0) s2 = 4'($urandom_range(15));
      if (!endgame && $urandom_range(49) == 0) endgame = 1;
      else if (endgame && $urandom_range(4) == 0) endgame = 0;
      model_edge(start_btn, s1, s2, endgame);
      step(1);
      check("random", model_out());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
